// File: rtl/instruction_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: bus widths, enable levels,
// the zero instruction word and the fetch FSM state encodings.
package instruction_fetch_unit_pkg;

  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

  localparam int INST_ADDR_BUS = 32;
  localparam int INST_DATA_BUS = 32;

  localparam logic [INST_DATA_BUS-1:0] ZERO_WORD = '0;

  typedef enum logic [1:0] {
    FETCH_BOOT = 2'd0,
    FETCH_RUN  = 2'd1,
    FETCH_HELD = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_pc_register.sv
// Program counter with next-value selection: reset vector, branch target,
// sequential advance (pc+4, wrapping) or hold.
module fetch_pc_register
  import instruction_fetch_unit_pkg::*;
#(
  parameter int                    ADDR_WIDTH   = INST_ADDR_BUS,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  branch_enable,
  input  logic [ADDR_WIDTH-1:0] branch_target,
  input  logic                  advance,
  output logic [ADDR_WIDTH-1:0] pc
);

  // A redirect wins even under stall or flush so that a branch is never lost.
  always_ff @(posedge clock) begin
    if (reset) begin
      pc <= RESET_VECTOR;
    end else if (branch_enable == ENABLE) begin
      pc <= branch_target;
    end else if (advance == ENABLE) begin
      pc <= pc + ADDR_WIDTH'(4);
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage: PC ownership, imem handshake and the IF/ID output register.
// Optional FETCH_PERF_COUNTER_EN adds saturating fetch_count / stall_count outputs.
//
// state      | meaning
// FETCH_BOOT | first cycle after reset, no fetch request
// FETCH_RUN  | normal fetching
// FETCH_HELD | stalled while presenting a valid instruction
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter int                    ADDR_WIDTH   = 32,
  parameter int                    DATA_WIDTH   = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  branch_enable,
  input  logic [ADDR_WIDTH-1:0] branch_target,
  output logic                  imem_request,
  output logic [ADDR_WIDTH-1:0] imem_address,
  input  logic                  imem_ready,
  input  logic [DATA_WIDTH-1:0] imem_data,
  output logic [ADDR_WIDTH-1:0] if_program_counter,
  output logic [DATA_WIDTH-1:0] if_instruction,
  output logic                  if_valid
`ifdef FETCH_PERF_COUNTER_EN
  ,
  output logic [31:0]           fetch_count,
  output logic [31:0]           stall_count
`endif
);

  fetch_state_t          state;
  logic [ADDR_WIDTH-1:0] pc;
  logic                  transfer;
  logic                  advance;

  assign imem_request = (state != FETCH_BOOT) && !stall && !reset;
  assign imem_address = pc;
  assign transfer     = imem_request && imem_ready;
  // A flushed word is dropped and refetched from the same pc.
  assign advance      = transfer && !flush;

  fetch_pc_register #(
    .ADDR_WIDTH   (ADDR_WIDTH),
    .RESET_VECTOR (RESET_VECTOR)
  ) u_fetch_pc_register (
    .clock         (clock),
    .reset         (reset),
    .branch_enable (branch_enable),
    .branch_target (branch_target),
    .advance       (advance),
    .pc            (pc)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state              <= FETCH_BOOT;
      if_valid           <= DISABLE;
      if_program_counter <= '0;
      if_instruction     <= DATA_WIDTH'(ZERO_WORD);
    end else begin
      case (state)
        FETCH_BOOT: state <= FETCH_RUN;
        default: begin
          if (flush)
            state <= FETCH_RUN;
          else if (stall)
            state <= if_valid ? FETCH_HELD : state;
          else
            state <= FETCH_RUN;
        end
      endcase

      if (flush) begin
        if_valid           <= DISABLE;
        if_program_counter <= '0;
        if_instruction     <= DATA_WIDTH'(ZERO_WORD);
      end else if (stall) begin
        if_valid <= if_valid;
      end else if (transfer) begin
        if_valid           <= ENABLE;
        if_program_counter <= pc;
        if_instruction     <= imem_data;
      end else if (imem_request) begin
        if_valid <= DISABLE;
      end
    end
  end

`ifdef FETCH_PERF_COUNTER_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_count <= '0;
      stall_count <= '0;
    end else begin
      if (advance && (fetch_count != 32'hFFFF_FFFF))
        fetch_count <= fetch_count + 32'd1;
      if (stall && (state != FETCH_BOOT) && (stall_count != 32'hFFFF_FFFF))
        stall_count <= stall_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit; memory returns address ^ MAGIC.
// Perf counter checks are built only with FETCH_PERF_COUNTER_EN.
module tb_instruction_fetch_unit;

  localparam logic [31:0] MAGIC = 32'hDEAD_0000;

  logic        clock = 1'b0;
  logic        reset, stall, flush, branch_enable, imem_ready;
  logic [31:0] branch_target;
  logic        imem_request;
  logic [31:0] imem_address, imem_data, if_program_counter, if_instruction;
  logic        if_valid;
`ifdef FETCH_PERF_COUNTER_EN
  logic [31:0] fetch_count, stall_count;
`endif

  int tests = 0;
  int failures = 0;

  always #5 clock = ~clock;

  assign imem_data = imem_address ^ MAGIC;

  instruction_fetch_unit dut (
    .clock              (clock),
    .reset              (reset),
    .stall              (stall),
    .flush              (flush),
    .branch_enable      (branch_enable),
    .branch_target      (branch_target),
    .imem_request       (imem_request),
    .imem_address       (imem_address),
    .imem_ready         (imem_ready),
    .imem_data          (imem_data),
    .if_program_counter (if_program_counter),
    .if_instruction     (if_instruction),
    .if_valid           (if_valid)
`ifdef FETCH_PERF_COUNTER_EN
    ,
    .fetch_count        (fetch_count),
    .stall_count        (stall_count)
`endif
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; stall = 1'b0; flush = 1'b0; branch_enable = 1'b0;
    branch_target = '0; imem_ready = 1'b1;
    tick(); tick();
    tests++; if (if_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got %b want 0", if_valid); end
    tests++; if (if_program_counter !== 32'h0) begin failures++; $display("FAIL reset_pc got %h want 0", if_program_counter); end
    tests++; if (if_instruction !== 32'h0) begin failures++; $display("FAIL reset_inst got %h want 0", if_instruction); end
    tests++; if (imem_request !== 1'b0) begin failures++; $display("FAIL reset_req got %b want 0", imem_request); end
    tests++; if (imem_address !== 32'h0) begin failures++; $display("FAIL reset_addr got %h want 0", imem_address); end
    reset = 1'b0;
    #1;
    tests++; if (imem_request !== 1'b0) begin failures++; $display("FAIL boot_req got %b want 0", imem_request); end
    tick();
    tests++; if ({imem_request, imem_address} !== {1'b1, 32'h0}) begin failures++; $display("FAIL first_req got %b/%h want 1/0", imem_request, imem_address); end
    tests++; if (if_valid !== 1'b0) begin failures++; $display("FAIL first_req_valid got %b want 0", if_valid); end
  endtask

  task automatic test_stream();
    logic [31:0] exp;
    for (int i = 0; i < 2; i++) begin
      exp = 32'(i * 4);
      tick();
      tests++; if ({if_valid, if_program_counter, if_instruction} !== {1'b1, exp, exp ^ MAGIC})
        begin failures++; $display("FAIL stream_%0d got %b/%h/%h want 1/%h/%h", i, if_valid, if_program_counter, if_instruction, exp, exp ^ MAGIC); end
    end
  endtask

  task automatic test_not_ready();
    imem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++; if ({if_valid, imem_address} !== {1'b0, 32'h8})
        begin failures++; $display("FAIL wait_%0d got valid %b addr %h want 0/8", i, if_valid, imem_address); end
    end
    imem_ready = 1'b1;
    tick();
    tests++; if ({if_valid, if_program_counter, if_instruction} !== {1'b1, 32'h8, 32'h8 ^ MAGIC})
      begin failures++; $display("FAIL ready_deliver got %b/%h/%h want 1/8", if_valid, if_program_counter, if_instruction); end
    tick(); tick();
  endtask

  task automatic test_stall();
    tests++; if (if_program_counter !== 32'h10) begin failures++; $display("FAIL pre_stall_pc got %h want 10", if_program_counter); end
    stall = 1'b1;
    #1;
    tests++; if (imem_request !== 1'b0) begin failures++; $display("FAIL stall_req got %b want 0", imem_request); end
    for (int i = 0; i < 2; i++) begin
      tick();
      tests++; if ({imem_request, if_valid, if_program_counter, if_instruction} !== {1'b0, 1'b1, 32'h10, 32'h10 ^ MAGIC})
        begin failures++; $display("FAIL stall_hold_%0d got %b/%b/%h want 0/1/10", i, imem_request, if_valid, if_program_counter); end
    end
    stall = 1'b0;
    tick();
    tests++; if ({if_valid, if_program_counter} !== {1'b1, 32'h14})
      begin failures++; $display("FAIL stall_release got %b/%h want 1/14", if_valid, if_program_counter); end
  endtask

  task automatic test_branch();
    tick(); tick();
    branch_enable = 1'b1; branch_target = 32'h100;
    tick();
    branch_enable = 1'b0;
    tests++; if ({if_valid, if_program_counter, imem_address} !== {1'b1, 32'h20, 32'h100})
      begin failures++; $display("FAIL delay_slot got %b/%h addr %h want 1/20/100", if_valid, if_program_counter, imem_address); end
    tick();
    tests++; if ({if_valid, if_program_counter, if_instruction} !== {1'b1, 32'h100, 32'h100 ^ MAGIC})
      begin failures++; $display("FAIL branch_tgt got %b/%h/%h want 1/100", if_valid, if_program_counter, if_instruction); end
    tick();
    tests++; if (if_program_counter !== 32'h104) begin failures++; $display("FAIL branch_next got %h want 104", if_program_counter); end
  endtask

  task automatic test_flush();
    branch_enable = 1'b1; branch_target = 32'h40;
    tick();
    flush = 1'b1; branch_target = 32'h80;
    tick();
    flush = 1'b0; branch_enable = 1'b0;
    tests++; if ({if_valid, if_program_counter, if_instruction, imem_address} !== {1'b0, 32'h0, 32'h0, 32'h80})
      begin failures++; $display("FAIL flush_branch got %b/%h/%h addr %h want 0/0/0/80", if_valid, if_program_counter, if_instruction, imem_address); end
    tick();
    tests++; if ({if_valid, if_program_counter} !== {1'b1, 32'h80})
      begin failures++; $display("FAIL after_flush got %b/%h want 1/80", if_valid, if_program_counter); end
    // Plain flush: the word at 0x84 is dropped and refetched.
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tests++; if ({if_valid, imem_address} !== {1'b0, 32'h84})
      begin failures++; $display("FAIL flush_only got %b addr %h want 0/84", if_valid, imem_address); end
    tick();
    tests++; if ({if_valid, if_program_counter} !== {1'b1, 32'h84})
      begin failures++; $display("FAIL refetch got %b/%h want 1/84", if_valid, if_program_counter); end
  endtask

  task automatic test_stall_branch();
    stall = 1'b1; branch_enable = 1'b1; branch_target = 32'h200;
    tick();
    stall = 1'b0; branch_enable = 1'b0;
    tests++; if ({if_valid, if_program_counter, imem_address} !== {1'b1, 32'h84, 32'h200})
      begin failures++; $display("FAIL stall_branch got %b/%h addr %h want 1/84/200", if_valid, if_program_counter, imem_address); end
    tick();
    tests++; if (if_program_counter !== 32'h200) begin failures++; $display("FAIL stall_branch_tgt got %h want 200", if_program_counter); end
  endtask

  task automatic test_wrap();
    branch_enable = 1'b1; branch_target = 32'hFFFF_FFFC;
    tick();
    branch_enable = 1'b0;
    tick();
    tests++; if ({if_valid, if_program_counter, imem_address} !== {1'b1, 32'hFFFF_FFFC, 32'h0})
      begin failures++; $display("FAIL wrap got %b/%h addr %h want 1/fffffffc/0", if_valid, if_program_counter, imem_address); end
  endtask

  task automatic test_mid_reset();
    reset = 1'b1;
    tick();
    tests++; if ({if_valid, if_program_counter, if_instruction, imem_address, imem_request} !== {1'b0, 32'h0, 32'h0, 32'h0, 1'b0})
      begin failures++; $display("FAIL mid_reset got %b/%h/%h addr %h req %b want all 0", if_valid, if_program_counter, if_instruction, imem_address, imem_request); end
    reset = 1'b0;
    tick();
  endtask

`ifdef FETCH_PERF_COUNTER_EN
  task automatic test_perf_counters();
    for (int i = 0; i < 4; i++) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0; stall = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    stall = 1'b0;
    tests++; if (fetch_count !== 32'd4) begin failures++; $display("FAIL fetch_count got %0d want 4", fetch_count); end
    tests++; if (stall_count !== 32'd3) begin failures++; $display("FAIL stall_count got %0d want 3", stall_count); end
    force dut.fetch_count = 32'hFFFF_FFFF;
    #1;
    release dut.fetch_count;
    tick();
    tests++; if (fetch_count !== 32'hFFFF_FFFF) begin failures++; $display("FAIL fetch_sat got %h want ffffffff", fetch_count); end
  endtask
`endif

  initial begin
    test_reset();
    test_stream();
    test_not_ready();
    test_stall();
    test_branch();
    test_flush();
    test_stall_branch();
    test_wrap();
    test_mid_reset();
`ifdef FETCH_PERF_COUNTER_EN
    test_perf_counters();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
